output_logic_read_mem_datos: RTL and testbench

OUTPUT_LOGIC_READ_MEM_DATOS -- requirements
Module: output_logic_read_mem_datos

---
 rtl/output_logic_read_mem_datos.sv | 84 ++++++++
 tb/tb_output_logic_read_mem_datos.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/output_logic_read_mem_datos.sv
// Load-data output stage behind a synchronous data BRAM: latch the request, then align/extend the returned word.
// Optional macro LOAD_MISALIGN_EXC_EN: misaligned halfword/word loads return 0 with o_error set.
module output_logic_read_mem_datos #(
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int CANT_BITS_DATA                  = 32,
  localparam int LSB_W = (CANT_COLUMNAS_MEM_DATOS > 1) ? $clog2(CANT_COLUMNAS_MEM_DATOS) : 1
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_read_mem,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
  input  logic [LSB_W-1:0]                           i_address_mem_LSB,
  input  logic                                       i_flush,
  input  logic [CANT_BITS_DATA-1:0]                  i_dato_mem,
  output logic [CANT_BITS_DATA-1:0]                  o_dato,
  output logic                                       o_valid,
  output logic                                       o_busy,
  output logic                                       o_error
);

  localparam int NUM_HALF = CANT_COLUMNAS_MEM_DATOS / 2;
  localparam int HSEL_W   = (NUM_HALF > 1) ? $clog2(NUM_HALF) : 1;

  // vld_pipe[0]: stage-1 request held, vld_pipe[1]: result registered
  logic [1:0]                                 vld_pipe;
  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] s1_sel;
  logic [LSB_W-1:0]                           s1_lsb;

  logic [CANT_COLUMNAS_MEM_DATOS-1:0][7:0]    lanes;
  logic [NUM_HALF-1:0][15:0]                  halves;
  logic [7:0]                                 byte_q;
  logic [15:0]                                half_q;
  logic [CANT_BITS_DATA-1:0]                  dato_nxt;
  logic                                       misalign;
  logic                                       capture;

  assign lanes   = i_dato_mem;
  assign halves  = i_dato_mem;
  assign byte_q  = lanes[s1_lsb];
  assign half_q  = halves[s1_lsb[LSB_W-1 -: HSEL_W]];
  // A flush kills the request currently in stage 1; the BRAM word is dropped with it
  assign capture = vld_pipe[0] & ~i_flush;

  always_comb begin
    dato_nxt = '0;
    misalign = 1'b0;
    case (s1_sel[1:0])
      2'd1: dato_nxt = s1_sel[2] ? {{(CANT_BITS_DATA-8){1'b0}}, byte_q}
                                 : {{(CANT_BITS_DATA-8){byte_q[7]}}, byte_q};
      2'd2: dato_nxt = s1_sel[2] ? {{(CANT_BITS_DATA-16){1'b0}}, half_q}
                                 : {{(CANT_BITS_DATA-16){half_q[15]}}, half_q};
      2'd3: dato_nxt = i_dato_mem;
      default: dato_nxt = '0;
    endcase
`ifdef LOAD_MISALIGN_EXC_EN
    misalign = ((s1_sel[1:0] == 2'd2) && s1_lsb[0]) ||
               ((s1_sel[1:0] == 2'd3) && (s1_lsb != '0));
    if (misalign) dato_nxt = '0;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_pipe <= '0;
      s1_sel   <= '0;
      s1_lsb   <= '0;
      o_dato   <= '0;
      o_error  <= 1'b0;
    end else begin
      vld_pipe <= {capture, i_read_mem};
      if (i_read_mem) begin
        s1_sel <= i_select_bytes_mem_datos;
        s1_lsb <= i_address_mem_LSB;
      end
      o_error <= capture & misalign;
      if (capture) o_dato <= dato_nxt;
    end
  end

  assign o_valid = vld_pipe[1];
  assign o_busy  = vld_pipe[0];

endmodule

// File: tb/tb_output_logic_read_mem_datos.sv
// Scoreboard bench: driver pushes expected load results, negedge monitor pops on o_valid.
module tb_output_logic_read_mem_datos;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_read_mem = 1'b0;
  logic [2:0]  i_select_bytes_mem_datos = '0;
  logic [1:0]  i_address_mem_LSB = '0;
  logic        i_flush = 1'b0;
  logic [31:0] i_dato_mem = '0;
  logic [31:0] o_dato;
  logic        o_valid, o_busy, o_error;

  output_logic_read_mem_datos dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_read_mem(i_read_mem),
    .i_select_bytes_mem_datos(i_select_bytes_mem_datos),
    .i_address_mem_LSB(i_address_mem_LSB), .i_flush(i_flush),
    .i_dato_mem(i_dato_mem), .o_dato(o_dato), .o_valid(o_valid),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] d;
    bit          e;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          rst_q = 1'b0;
  bit          exp_busy = 1'b0;
  logic [31:0] last_dato = '0;

  // stage-1 shadow kept by the driver
  bit          pend_v = 1'b0;
  logic [2:0]  pend_sel;
  logic [1:0]  pend_lsb;
  logic [31:0] pend_word;

  always @(posedge i_clock) begin
    cyc   <= cyc + 1;
    rst_q <= i_reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Load semantics written as plain arithmetic on the memory word
  function automatic void ref_load(input logic [31:0] w, input logic [2:0] sel,
                                   input logic [1:0] lsb, output logic [31:0] d, output bit e);
    int unsigned v;
    d = 0;
    e = 0;
    case (sel[1:0])
      2'd1: begin
        v = (w >> (8 * lsb)) & 32'hFF;
        if (!sel[2] && v >= 128) v = v + 32'hFFFFFF00;
        d = v;
      end
      2'd2: begin
`ifdef LOAD_MISALIGN_EXC_EN
        if (lsb % 2 == 1) begin e = 1; return; end
`endif
        v = (w >> (16 * (lsb / 2))) & 32'hFFFF;
        if (!sel[2] && v >= 32768) v = v + 32'hFFFF0000;
        d = v;
      end
      2'd3: begin
`ifdef LOAD_MISALIGN_EXC_EN
        if (lsb != 0) begin e = 1; return; end
`endif
        d = w;
      end
      default: d = 0;
    endcase
  endfunction

  // One cycle of stimulus; w is the BRAM word returned for this request next cycle
  task automatic step(input bit req, input logic [2:0] sel, input logic [1:0] lsb,
                      input logic [31:0] w, input bit fl, input bit rs);
    exp_t x;
    @(posedge i_clock);
    #1;
    exp_busy   = pend_v;
    i_reset    = rs;
    i_flush    = fl;
    i_dato_mem = pend_v ? pend_word : $urandom;
    if (pend_v && !fl && !rs) begin
      ref_load(pend_word, pend_sel, pend_lsb, x.d, x.e);
      x.due = cyc + 1;
      q.push_back(x);
    end
    i_read_mem               = req;
    i_select_bytes_mem_datos = sel;
    i_address_mem_LSB        = lsb;
    pend_v    = req && !rs;
    pend_sel  = sel;
    pend_lsb  = lsb;
    pend_word = w;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 3'($urandom), 2'($urandom), $urandom, 0, 0);
  endtask

  always @(negedge i_clock) begin
    exp_t x;
    if (rst_q) begin
      chk("reset_valid", {31'b0, o_valid}, 32'd0);
      chk("reset_dato",  o_dato, 32'd0);
      chk("reset_busy",  {31'b0, o_busy}, 32'd0);
      chk("reset_error", {31'b0, o_error}, 32'd0);
      last_dato = '0;
    end else if (cyc > 0) begin
      chk("busy", {31'b0, o_busy}, {31'b0, exp_busy});
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {31'b0, o_valid}, 32'd0);
        end else begin
          x = q.pop_front();
          chk("valid_latency", cyc, x.due);
          chk("dato",  o_dato, x.d);
          chk("error", {31'b0, o_error}, {31'b0, x.e});
          last_dato = x.d;
        end
      end else begin
        chk("dato_hold", o_dato, last_dato);
        if (q.size() != 0 && q[0].due <= cyc) begin
          chk("missing_valid", {31'b0, o_valid}, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 0, 0, 1);
    step(1, 3'b001, 2, 32'h12F45678, 0, 0);   // LB
    step(1, 3'b101, 2, 32'h12F45678, 0, 0);   // LBU
    step(1, 3'b110, 2, 32'h12F45678, 0, 0);   // LHU
    step(1, 3'b010, 0, 32'h00008001, 0, 0);   // LH then LW back-to-back
    step(1, 3'b011, 0, 32'hDEADBEEF, 0, 0);
    idle(3);
    step(1, 3'b011, 0, 32'h11111111, 0, 0);   // flushed next cycle
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 3'b011, 0, 32'h22222222, 0, 0);   // flush with a new request alongside
    step(1, 3'b001, 3, 32'h80000000, 1, 0);
    idle(2);
    step(1, 3'b011, 0, 32'h33333333, 0, 0);   // reset mid-op
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    step(1, 3'b011, 1, 32'hCAFEBABE, 0, 0);   // misaligned LW
    step(1, 3'b000, 0, 32'hFFFFFFFF, 0, 0);   // size 0
    step(1, 3'b010, 3, 32'h8001F00F, 0, 0);   // halfword odd offset
    step(1, 3'b110, 1, 32'h8001F00F, 0, 0);
    idle(3);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, 3'($urandom), 2'($urandom), $urandom,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    idle(4);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
